parity_gen_multi: RTL and testbench
===================================

// Module: parity_gen_multi
// PURPOSE
//   AXI4-Lite slave that computes even/odd parity over NUM_CH data words.
//   The engine is serial: it folds LANE_W bits per cycle under an FSM.
//   Status is a sticky DONE flag plus an optional level interrupt.
//   It supersedes the single-function 4-register parity IP in the block design.
//   It is instantiated behind the PS AXI interconnect on S00_AXI.
// PARAMETERS
//   C_S_AXI_DATA_WIDTH  32  AXI data width (fixed 32)
//   C_S_AXI_ADDR_WIDTH  6   byte address width; requires 0x10+4*NUM_CH <= 2**C_S_AXI_ADDR_WIDTH
//   NUM_CH              4   number of channels, 1..12
//   DATA_WIDTH          32  bits per channel covered by parity; 1..32; multiple of LANE_W
//   LANE_W              8   bits folded per cycle; 1..DATA_WIDTH
// PORTS
//   ACLK     in   1       clock
//   ARESETN  in   1       synchronous reset, active-low
//   s_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready,
//   bresp/bvalid/bready, araddr/arprot/arvalid/arready,
//   rdata/rresp/rvalid/rready   standard AXI4-Lite widths
//   irq      out  1       level interrupt = DONE & IRQ_EN
// BEHAVIOUR
// - Reset (ARESETN=0 at a rising edge): all outputs 0; all registers 0; FSM to IDLE.
//   Applies mid-operation: the accumulator, counter, DONE and RESULT all clear.
// - Register map (byte offsets):
//     0x00 CTRL    b0 START (W1, self-clearing, reads 0), b1 ODD, b2 IRQ_EN
//     0x04 STATUS  b0 BUSY (RO), b1 DONE (sticky, W1C)
//     0x08 RESULT  RO; [NUM_CH-1:0] parity per channel; upper bits 0
//     0x0C         reserved; reads 0; writes ignored
//     0x10+4*i     DATA[i], RW, i < NUM_CH
//   Unmapped reads return 0/OKAY. Unmapped writes are dropped with OKAY.
// - Write channel:
//   - Accept only when AWVALID & WVALID & !BVALID.
//   - AWREADY and WREADY pulse together for 1 cycle; the register updates on that edge.
//   - BVALID rises the next cycle and holds until BREADY.
//   - Only one write is outstanding at a time.
//   - WSTRB is honoured per byte.
// - Read channel:
//   - ARREADY pulses 1 cycle when ARVALID & !RVALID.
//   - RDATA is registered; RVALID rises the next cycle and holds until RREADY.
//   - Read and write channels are independent. A same-cycle read of a register being written returns the old value.
// - FSM states:
//   - IDLE -> CALC on an accepted write with CTRL.START=1 while IDLE.
//     Entry clears the accumulators and cnt=0, clears DONE, and latches ODD.
//   - CALC: each cycle acc[ch] ^= ^DATA[ch][cnt*LANE_W +: LANE_W] and cnt++.
//     When cnt == DATA_WIDTH/LANE_W-1, go to IDLE.
//     That same edge writes RESULT = acc_next ^ {NUM_CH{ODD}} and sets DONE.
//   - BUSY = (state==CALC); busy for exactly DATA_WIDTH/LANE_W cycles,
//     starting the cycle after the START write handshake.
// - Boundary rules:
//   - START while BUSY: ignored; BRESP OKAY.
//   - Write to DATA[i] while BUSY: data unchanged; BRESP=SLVERR (2'b10).
//     Writes to CTRL.ODD/IRQ_EN while BUSY are allowed; ODD is used as latched at start.
//   - DONE W1C in the same cycle as completion: set wins, DONE stays 1.
//   - RESULT holds its value until the next completion or reset.
//   - DATA_WIDTH==LANE_W: single-cycle CALC.
// STRUCTURE
// - Package parity_gen_pkg:
//   - register offset localparams (CTRL/STATUS/RESULT/DATA_BASE);
//   - CTRL/STATUS bit indices;
//   - typedef enum logic {IDLE, CALC} pg_state_t;
//   - BRESP constants OKAY/SLVERR.
// - Sub-module parity_fold_engine: FSM, counter, per-channel accumulators, RESULT/DONE generation.
//   Inputs: start, odd, data array. Outputs: busy, done_set, result.
// - Top level: AXI4-Lite slave, register file, irq.
// TESTING
// 1 Reset: hold ARESETN=0 for 5 cycles -> all outputs 0; read STATUS=0, RESULT=0, DATA0=0.
// 2 NUM_CH=4, DATA_WIDTH=32, LANE_W=8: write DATA0..3=1,2,3,7; write CTRL=0x1
//   -> BUSY for 4 cycles, then DONE=1, RESULT=0xB.
//   Repeat with CTRL=0x3 -> RESULT=0x4.
// 3 Write DATA1=0xFF while BUSY -> BRESP=SLVERR; DATA1 reads 2; RESULT unaffected.
// 4 With IRQ_EN=1, completion -> irq=1. Write STATUS=0x2 -> irq=0 next cycle.
//   Issue W1C on the completion cycle -> DONE stays 1.
// 5 Drop ARESETN for 1 cycle during CALC -> BUSY=0, DONE=0, RESULT=0, irq=0; no spurious BVALID.
// 6 Hold BREADY=0 for 3 cycles with a second AW/W pending -> AWREADY/WREADY stay 0
//   until B completes; then the second write is accepted; both values read back correctly.

Source files
------------

// File: rtl/parity_gen_pkg.sv
// Shared definitions for the multi-channel parity generator: register map,
// control/status bit positions, response codes and the fold-engine state type.
package parity_gen_pkg;

    localparam int unsigned OFF_CTRL      = 32'h00;
    localparam int unsigned OFF_STATUS    = 32'h04;
    localparam int unsigned OFF_RESULT    = 32'h08;
    localparam int unsigned OFF_DATA_BASE = 32'h10;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_ODD    = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } pg_state_t;

endpackage

// File: rtl/parity_gen_multi_engine.sv
// Serial parity fold engine: walks LANE_W-bit slices of every channel word,
// one slice per cycle, and publishes per-channel parity with a one-cycle done pulse.
module parity_fold_engine
    import parity_gen_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LANE_W     = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               odd,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]  data,
    output logic                               busy,
    output logic                               done_set,
    output logic [NUM_CH-1:0]                  result
);

    localparam int BEATS = DATA_WIDTH / LANE_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    pg_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] acc_q, acc_d, acc_next;
    logic [NUM_CH-1:0] result_q, result_d;
    logic              odd_q, odd_d;

    // Slice selection uses only constant part-selects, one per beat position.
    always_comb begin
        acc_next = acc_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int b = 0; b < BEATS; b++) begin
                if (cnt_q == CNT_W'(b)) begin
                    acc_next[ch] = acc_q[ch] ^ (^data[ch][b*LANE_W +: LANE_W]);
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        odd_d    = odd_q;
        result_d = result_q;
        done_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    acc_d   = '0;
                    odd_d   = odd;
                end
            end
            CALC: begin
                acc_d = acc_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    result_d = acc_next ^ {NUM_CH{odd_q}};
                    done_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            odd_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            odd_q    <= odd_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == CALC);
    assign result = result_q;

endmodule

// File: rtl/parity_gen_multi.sv
// AXI4-Lite front end for the parity fold engine: register file, single
// outstanding write/read handshakes, sticky DONE and level interrupt.
module parity_gen_multi
    import parity_gen_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_CH             = 4,
    parameter int DATA_WIDTH         = 32,
    parameter int LANE_W             = 8
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [2:0]                        s_axi_awprot,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,
    output logic [1:0]                        s_axi_bresp,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [2:0]                        s_axi_arprot,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                        s_axi_rresp,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready,
    output logic                              irq
);

    localparam int WIDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam int NBYTES = C_S_AXI_DATA_WIDTH / 8;

    logic [WIDX_W-1:0] aw_idx, ar_idx;
    assign aw_idx = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_idx = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];

    function automatic logic idx_is(input logic [WIDX_W-1:0] idx, input int unsigned off);
        return idx == WIDX_W'(off >> 2);
    endfunction

    logic                              awready_q, awready_d;
    logic                              bvalid_q, bvalid_d;
    logic [1:0]                        bresp_q, bresp_d;
    logic                              arready_q, arready_d;
    logic                              rvalid_q, rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic                              odd_q, odd_d;
    logic                              irq_en_q, irq_en_d;
    logic                              done_q, done_d;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] data_q, data_d;

    logic                              wr_en, rd_en, start, done_clr;
    logic                              busy, done_set;
    logic [NUM_CH-1:0]                 result;
    logic [C_S_AXI_DATA_WIDTH-1:0]     merged;

    parity_fold_engine #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DATA_WIDTH),
        .LANE_W     (LANE_W)
    ) u_engine (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .start    (start),
        .odd      (odd_d),
        .data     (data_q),
        .busy     (busy),
        .done_set (done_set),
        .result   (result)
    );

    // Write channel: AWREADY/WREADY pulse once per write, no new write while B is pending.
    always_comb begin
        wr_en     = awready_q & s_axi_awvalid & s_axi_wvalid;
        awready_d = s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~awready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        data_d    = data_q;
        odd_d     = odd_q;
        irq_en_d  = irq_en_q;
        start     = 1'b0;
        done_clr  = 1'b0;
        merged    = '0;

        if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end

        if (wr_en) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            if (idx_is(aw_idx, OFF_CTRL)) begin
                if (s_axi_wstrb[0]) begin
                    odd_d    = s_axi_wdata[CTRL_ODD];
                    irq_en_d = s_axi_wdata[CTRL_IRQ_EN];
                    start    = s_axi_wdata[CTRL_START] & ~busy;
                end
            end else if (idx_is(aw_idx, OFF_STATUS)) begin
                done_clr = s_axi_wstrb[0] & s_axi_wdata[STAT_DONE];
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (aw_idx == WIDX_W'((OFF_DATA_BASE >> 2) + i)) begin
                        if (busy) begin
                            bresp_d = RESP_SLVERR;
                        end else begin
                            merged = C_S_AXI_DATA_WIDTH'(data_q[i]);
                            for (int b = 0; b < NBYTES; b++) begin
                                if (s_axi_wstrb[b]) begin
                                    merged[b*8 +: 8] = s_axi_wdata[b*8 +: 8];
                                end
                            end
                            data_d[i] = merged[DATA_WIDTH-1:0];
                        end
                    end
                end
            end
        end
    end

    // Completion outranks a coincident W1C so a finished run is never lost.
    always_comb begin
        done_d = done_q;
        if (done_clr || start) begin
            done_d = 1'b0;
        end
        if (done_set) begin
            done_d = 1'b1;
        end
    end

    // Read channel samples current register state, so a same-edge write is not visible yet.
    always_comb begin
        rd_en     = arready_q & s_axi_arvalid;
        arready_d = s_axi_arvalid & ~rvalid_q & ~arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;

        if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end

        if (rd_en) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            if (idx_is(ar_idx, OFF_CTRL)) begin
                rdata_d[CTRL_ODD]    = odd_q;
                rdata_d[CTRL_IRQ_EN] = irq_en_q;
            end else if (idx_is(ar_idx, OFF_STATUS)) begin
                rdata_d[STAT_BUSY] = busy;
                rdata_d[STAT_DONE] = done_q;
            end else if (idx_is(ar_idx, OFF_RESULT)) begin
                rdata_d = C_S_AXI_DATA_WIDTH'(result);
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ar_idx == WIDX_W'((OFF_DATA_BASE >> 2) + i)) begin
                        rdata_d = C_S_AXI_DATA_WIDTH'(data_q[i]);
                    end
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            odd_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= '0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            odd_q     <= odd_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            data_q    <= data_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = RESP_OKAY;
    assign irq           = done_q & irq_en_q;

    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_parity_gen_multi.sv
// Directed bench for parity_gen_multi with default parameters (4 channels,
// 32-bit words folded 8 bits per cycle).
module tb_parity_gen_multi;

    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_STATUS = 6'h04;
    localparam logic [5:0] A_RESULT = 6'h08;
    localparam logic [5:0] A_DATA0  = 6'h10;
    localparam logic [5:0] A_DATA1  = 6'h14;
    localparam logic [5:0] A_DATA2  = 6'h18;
    localparam logic [5:0] A_DATA3  = 6'h1C;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [5:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic        irq;

    int checks = 0;
    int failures = 0;

    always #5 ACLK = ~ACLK;

    parity_gen_multi dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (awprot),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .irq           (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int g;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        g = 0;
        @(negedge ACLK);
        while (!awready && g < 50) begin @(negedge ACLK); g++; end
        if (!awready) chk("aw_timeout", 32'd0, 32'd1);
        @(posedge ACLK); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        g = 0;
        @(negedge ACLK);
        while (!bvalid && g < 50) begin @(negedge ACLK); g++; end
        if (!bvalid) chk("b_timeout", 32'd0, 32'd1);
        resp = bresp;
        @(posedge ACLK); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data);
        int g;
        araddr = addr; arvalid = 1'b1;
        g = 0;
        @(negedge ACLK);
        while (!arready && g < 50) begin @(negedge ACLK); g++; end
        if (!arready) chk("ar_timeout", 32'd0, 32'd1);
        @(posedge ACLK); #1;
        arvalid = 1'b0; rready = 1'b1;
        g = 0;
        @(negedge ACLK);
        while (!rvalid && g < 50) begin @(negedge ACLK); g++; end
        if (!rvalid) chk("r_timeout", 32'd0, 32'd1);
        data = rdata;
        @(posedge ACLK); #1;
        rready = 1'b0;
    endtask

    task automatic poll_done(output logic [31:0] st);
        int g = 0;
        axi_read(A_STATUS, st);
        while (!st[1] && g < 20) begin axi_read(A_STATUS, st); g++; end
    endtask

    task automatic measure_busy(output int n);
        int g = 0;
        n = 0;
        while (!dut.busy && g < 50) begin @(negedge ACLK); g++; end
        while (dut.busy && n < 50) begin @(negedge ACLK); n++; end
    endtask

    initial begin
        logic [31:0] rd, st;
        logic [1:0]  resp, resp2;
        logic        seen;
        int          nb;

        ARESETN = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = 4'hF; wvalid = 0;
        bready = 0; araddr = '0; arprot = '0; arvalid = 0; rready = 0;

        // 1: reset
        repeat (5) @(posedge ACLK);
        #1;
        chk("rst_outs", 32'({awready, wready, bvalid, bresp, arready, rvalid, rresp, irq}), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        axi_read(A_STATUS, rd); chk("rst_status", rd, 32'd0);
        axi_read(A_RESULT, rd); chk("rst_result", rd, 32'd0);
        axi_read(A_DATA0, rd);  chk("rst_data0", rd, 32'd0);

        // 2: even then odd parity over 1,2,3,7
        axi_write(A_DATA0, 32'd1, 4'hF, resp);
        axi_write(A_DATA1, 32'd2, 4'hF, resp);
        axi_write(A_DATA2, 32'd3, 4'hF, resp);
        axi_write(A_DATA3, 32'd7, 4'hF, resp);
        chk("data_wr_resp", 32'(resp), 32'd0);
        fork
            axi_write(A_CTRL, 32'h1, 4'hF, resp);
            measure_busy(nb);
        join
        chk("busy_cycles", 32'(nb), 32'd4);
        poll_done(st);          chk("even_status", st, 32'h2);
        axi_read(A_RESULT, rd); chk("even_result", rd, 32'hB);
        axi_write(A_CTRL, 32'h3, 4'hF, resp);
        poll_done(st);
        axi_read(A_RESULT, rd); chk("odd_result", rd, 32'h4);
        axi_read(A_CTRL, rd);   chk("ctrl_readback", rd, 32'h2);

        // 3: DATA write while busy
        axi_write(A_CTRL, 32'h1, 4'hF, resp);
        axi_write(A_DATA1, 32'hFF, 4'hF, resp);
        chk("busy_data_slverr", 32'(resp), 32'd2);
        poll_done(st);
        axi_read(A_RESULT, rd); chk("busy_wr_result", rd, 32'hB);
        axi_read(A_DATA1, rd);  chk("busy_wr_data1", rd, 32'd2);

        // 4: interrupt and W1C
        axi_write(A_STATUS, 32'h2, 4'hF, resp);
        chk("irq_after_clr0", 32'(irq), 32'd0);
        axi_write(A_CTRL, 32'h5, 4'hF, resp);
        poll_done(st);
        chk("irq_set", 32'(irq), 32'd1);
        axi_write(A_STATUS, 32'h2, 4'hF, resp);
        chk("irq_w1c", 32'(irq), 32'd0);
        axi_write(A_CTRL, 32'h5, 4'hF, resp);
        @(posedge ACLK); #1;
        axi_write(A_STATUS, 32'h2, 4'hF, resp);
        axi_read(A_STATUS, rd); chk("w1c_vs_set", rd, 32'h2);
        chk("irq_after_collide", 32'(irq), 32'd1);

        // 5: reset during CALC
        axi_write(A_CTRL, 32'h5, 4'hF, resp);
        chk("busy_before_rst", 32'(dut.busy), 32'd1);
        ARESETN = 1'b0;
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        chk("rst_mid_irq", 32'(irq), 32'd0);
        seen = 1'b0;
        repeat (3) begin @(negedge ACLK); seen = seen | bvalid; end
        chk("rst_mid_no_bvalid", 32'(seen), 32'd0);
        axi_read(A_STATUS, rd); chk("rst_mid_status", rd, 32'd0);
        axi_read(A_RESULT, rd); chk("rst_mid_result", rd, 32'd0);
        axi_write(A_DATA0, 32'hAABBCCDD, 4'b0101, resp);
        axi_read(A_DATA0, rd);  chk("wstrb_merge", rd, 32'h00BB00DD);

        // 6: back-pressure on B with a second write pending
        @(posedge ACLK); #1;
        awaddr = A_DATA2; wdata = 32'hA5A50001; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        nb = 0;
        @(negedge ACLK);
        while (!awready && nb < 50) begin @(negedge ACLK); nb++; end
        if (!awready) chk("bp_aw1_timeout", 32'd0, 32'd1);
        @(posedge ACLK); #1;
        awaddr = A_DATA3; wdata = 32'h12345678;
        seen = 1'b0;
        repeat (3) begin @(negedge ACLK); seen = seen | awready | wready; end
        chk("bp_ready_held", 32'(seen), 32'd0);
        chk("bp_bvalid_held", 32'({bvalid, bresp}), 32'h4);
        bready = 1'b1;
        @(posedge ACLK); #1;
        bready = 1'b0;
        nb = 0;
        @(negedge ACLK);
        while (!awready && nb < 50) begin @(negedge ACLK); nb++; end
        if (!awready) chk("bp_aw2_timeout", 32'd0, 32'd1);
        @(posedge ACLK); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        nb = 0;
        @(negedge ACLK);
        while (!bvalid && nb < 50) begin @(negedge ACLK); nb++; end
        resp2 = bresp;
        chk("bp_b2", 32'({bvalid, resp2}), 32'h4);
        @(posedge ACLK); #1;
        bready = 1'b0;
        axi_read(A_DATA2, rd); chk("bp_data2", rd, 32'hA5A50001);
        axi_read(A_DATA3, rd); chk("bp_data3", rd, 32'h12345678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
